phy_mdio_ctrl: RTL

- Management-plane controller for the RGMII PHY on the rx board: drives MDC/MDIO, sequences PHY init after the reset release, then periodically polls link status.
- Status outputs (link up, speed, duplex) feed the rx datapath, where they select the rgmii_rx decode mode, and drive the debug LEDs.
- Arbitrates one shared MDIO bus between the internal init/poll sequencer and a single external register-access requester (UART debug path).

---
 rtl/phy_mdio_ctrl_if.sv | 21 ++
 rtl/phy_mdio_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_mdio_ctrl_if.sv
// Register-access port of the PHY management controller.
// One requester issues single MDIO reads/writes and gets a response pulse.
interface phy_mdio_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_reg, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_reg, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/phy_mdio_ctrl.sv
// RGMII PHY management: MDC/MDIO framing, BMCR init after reset,
// periodic status polling, and arbitration with one external requester.
module phy_mdio_ctrl #(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int          MDC_HALF      = 25,
  parameter int          POLL_INTERVAL = 1250000,
  parameter logic [4:0]  STATUS_REG    = 5'h11,
  parameter logic [15:0] BMCR_INIT     = 16'h1340
) (
  input  logic        clk125MHz,
  input  logic        resetn,
  input  logic        phy_ready,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  phy_mdio_ctrl_if.slave req,
  output logic        init_done,
  output logic        status_valid,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex,
  output logic        busy
);

  localparam int HW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [HW-1:0] HALF_END = HW'(MDC_HALF - 1);
  localparam logic [PW-1:0] POLL_END = PW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    WAIT_PHY,
    INIT_WR,
    IDLE,
    POLL_RD,
    USER_XFER
  } state_t;

  state_t state_q, state_d;

  logic [HW-1:0] hcnt;
  logic          hi;
  logic          gap;
  logic [5:0]    bit_idx;
  logic [63:0]   fr_sh;
  logic          fr_rd;
  logic          u_write;
  logic [15:0]   rd_sh;
  logic [PW-1:0] poll_cnt;
  logic          poll_pending;

  logic          accept;
  logic          half_end;
  logic          fr_done;
  logic          abort;
  logic          start;
  logic          f_wr;
  logic [4:0]    f_reg;
  logic [15:0]   f_data;
  logic [63:0]   frame;

  assign req.req_ready = (state_q == IDLE) && init_done;
  assign accept   = req.req_valid && req.req_ready;
  assign half_end = (hcnt == HALF_END);
  assign fr_done  = busy && gap && half_end;
  assign abort    = !phy_ready && (state_q != WAIT_PHY);

  always_ff @(posedge clk125MHz) begin
    if (!resetn) state_q <= WAIT_PHY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_PHY: if (phy_ready) state_d = INIT_WR;
      INIT_WR, POLL_RD, USER_XFER:
        if (fr_done) state_d = IDLE;
      IDLE: begin
        if (accept)            state_d = USER_XFER;
        else if (poll_pending) state_d = POLL_RD;
      end
      default: state_d = WAIT_PHY;
    endcase
    if (abort) state_d = WAIT_PHY;
  end

  assign start = (state_d != state_q) &&
                 (state_d == INIT_WR ||
                  state_d == POLL_RD ||
                  state_d == USER_XFER);

  // Frame word is built from the request inputs on the accept cycle.
  always_comb begin
    f_wr   = 1'b0;
    f_reg  = STATUS_REG;
    f_data = 16'hFFFF;
    unique case (1'b1)
      state_d == INIT_WR: begin
        f_wr   = 1'b1;
        f_reg  = 5'd0;
        f_data = BMCR_INIT;
      end
      state_d == USER_XFER: begin
        f_wr   = req.req_write;
        f_reg  = req.req_reg;
        f_data = req.req_write ? req.req_wdata : 16'hFFFF;
      end
      default: ;
    endcase
  end

  assign frame = {32'hFFFF_FFFF, 2'b01,
                  f_wr ? 2'b01 : 2'b10,
                  PHY_ADDR, f_reg,
                  f_wr ? 2'b10 : 2'b11,
                  f_data};

  always_ff @(posedge clk125MHz) begin
    if (!resetn) begin
      mdc           <= 1'b0;
      mdio_o        <= 1'b1;
      mdio_oe       <= 1'b0;
      busy          <= 1'b0;
      hcnt          <= '0;
      hi            <= 1'b0;
      gap           <= 1'b0;
      bit_idx       <= '0;
      fr_sh         <= '1;
      fr_rd         <= 1'b0;
      u_write       <= 1'b0;
      rd_sh         <= '0;
      poll_cnt      <= '0;
      poll_pending  <= 1'b0;
      init_done     <= 1'b0;
      status_valid  <= 1'b0;
      link_up       <= 1'b0;
      link_speed    <= 2'b00;
      full_duplex   <= 1'b0;
      req.rsp_valid <= 1'b0;
      req.rsp_rdata <= '0;
    end else begin
      req.rsp_valid <= 1'b0;
      if (state_q != WAIT_PHY)
        poll_cnt <= (poll_cnt == POLL_END) ? '0 : poll_cnt + 1'b1;
      if (state_q == POLL_RD && fr_done)
        poll_pending <= 1'b0;
      if (state_q != WAIT_PHY && poll_cnt == POLL_END)
        poll_pending <= 1'b1;

      if (abort) begin
        mdc          <= 1'b0;
        mdio_oe      <= 1'b0;
        mdio_o       <= 1'b1;
        busy         <= 1'b0;
        gap          <= 1'b0;
        init_done    <= 1'b0;
        status_valid <= 1'b0;
        link_up      <= 1'b0;
      end else if (start) begin
        busy    <= 1'b1;
        hcnt    <= '0;
        hi      <= 1'b0;
        gap     <= 1'b0;
        bit_idx <= '0;
        mdc     <= 1'b0;
        mdio_oe <= 1'b1;
        mdio_o  <= frame[63];
        fr_sh   <= {frame[62:0], 1'b1};
        fr_rd   <= !f_wr;
        u_write <= f_wr;
      end else if (busy) begin
        if (!half_end) begin
          hcnt <= hcnt + 1'b1;
        end else begin
          hcnt <= '0;
          if (gap) begin
            busy <= 1'b0;
            gap  <= 1'b0;
            unique case (state_q)
              INIT_WR: init_done <= 1'b1;
              POLL_RD: begin
                link_up      <= rd_sh[10];
                link_speed   <= rd_sh[15:14];
                full_duplex  <= rd_sh[13];
                status_valid <= 1'b1;
              end
              USER_XFER: begin
                req.rsp_valid <= 1'b1;
                req.rsp_rdata <= u_write ? 16'h0000 : rd_sh;
              end
              default: ;
            endcase
          end else if (!hi) begin
            hi    <= 1'b1;
            mdc   <= 1'b1;
            rd_sh <= {rd_sh[14:0], mdio_i};
          end else if (bit_idx == 6'd63) begin
            hi      <= 1'b0;
            mdc     <= 1'b0;
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            gap     <= 1'b1;
          end else begin
            hi      <= 1'b0;
            mdc     <= 1'b0;
            bit_idx <= bit_idx + 6'd1;
            mdio_o  <= fr_sh[63];
            fr_sh   <= {fr_sh[62:0], 1'b1};
            // Read frames release the line from the turnaround on.
            mdio_oe <= !(fr_rd && bit_idx >= 6'd45);
          end
        end
      end
    end
  end

endmodule
